// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// presents the fetched instruction to decode, and squashes wrong-path fetches.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [6:0]  opcode
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH,
    VALID
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target;

  assign target = branch_target & 32'hFFFF_FFFC;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    redir_d = redir_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          if (branch_taken) begin
            addr_d = target;
          end else begin
            instr_d = imem_rdata;
            pc_d    = addr_q;
            state_d = VALID;
          end
        end else if (branch_taken) begin
          // addr_q must stay put until the in-flight request completes
          redir_d = target;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (branch_taken) redir_d = target;
        if (imem_ready) begin
          addr_d  = branch_taken ? target : redir_q;
          state_d = FETCH;
        end
      end
      VALID: begin
        if (branch_taken) begin
          addr_d  = target;
          state_d = FETCH;
        end else if (!stall) begin
          addr_d  = pc_q + 32'd4;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      redir_q <= '0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      redir_q <= redir_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == FLUSH);
  assign imem_addr   = addr_q;
  assign instr_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign pc_out      = pc_q;
  assign opcode      = (state_q == VALID) ? instr_q[6:0] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle-level reference model compared every
// cycle, plus directed literal checks on the key scenarios.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [6:0]  opcode;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .opcode(opcode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks "request in flight", "in-flight is wrong-path",
  // and "holding an instruction" as independent facts.
  bit          m_init = 0;
  bit          m_busy, m_wrong, m_have;
  logic [31:0] m_addr, m_redir, m_instr, m_pc;

  always @(posedge clk) begin
    logic [31:0] t;
    t = {branch_target[31:2], 2'b00};
    if (reset) begin
      m_init = 1; m_busy = 0; m_wrong = 0; m_have = 0;
      m_addr = RST_PC; m_redir = 0; m_instr = 0; m_pc = 0;
    end else if (m_init) begin
      if (!m_busy) begin
        if (!m_have) m_busy = 1;
        else if (branch_taken) begin m_have = 0; m_addr = t; m_busy = 1; end
        else if (!stall) begin m_have = 0; m_addr = m_pc + 4; m_busy = 1; end
      end else if (m_wrong) begin
        if (branch_taken) m_redir = t;
        if (imem_ready) begin m_wrong = 0; m_addr = m_redir; end
      end else if (imem_ready) begin
        if (branch_taken) m_addr = t;
        else begin m_instr = imem_rdata; m_pc = m_addr; m_have = 1; m_busy = 0; end
      end else if (branch_taken) begin
        m_redir = t; m_wrong = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
      chk("imem_addr", imem_addr, m_addr);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
      chk("instr", instr, m_instr);
      chk("pc_out", pc_out, m_pc);
      chk("opcode", {25'b0, opcode}, m_have ? {25'b0, m_instr[6:0]} : 32'b0);
    end
  end

  task automatic step(input logic r, input logic st, input logic br,
                      input logic [31:0] tg, input logic rdy, input logic [31:0] rd);
    reset = r; stall = st; branch_taken = br; branch_target = tg;
    imem_ready = rdy; imem_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h33);
    chk("lit_rst_req", {31'b0, imem_req}, 0);
    chk("lit_rst_valid", {31'b0, instr_valid}, 0);
    chk("lit_rst_opcode", {25'b0, opcode}, 0);
    chk("lit_rst_addr", imem_addr, RST_PC);

    // zero-wait streaming
    step(0, 0, 0, 0, 1, 32'h33);
    chk("lit_first_req", {31'b0, imem_req}, 1);
    chk("lit_addr0", imem_addr, 32'h0);
    step(0, 0, 0, 0, 1, 32'h33);
    chk("lit_valid0", {31'b0, instr_valid}, 1);
    chk("lit_opc33", {25'b0, opcode}, 32'h33);
    step(0, 0, 0, 0, 1, 32'h33);
    chk("lit_addr4", imem_addr, 32'h4);
    chk("lit_opc_idle", {25'b0, opcode}, 0);
    step(0, 0, 0, 0, 1, 32'h33);
    step(0, 0, 0, 0, 1, 32'h33);
    chk("lit_addr8", imem_addr, 32'h8);
    step(0, 0, 0, 0, 1, 32'h33);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h33);

    // 3-cycle wait at 0x10
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("lit_wait_addr", imem_addr, 32'h10);
      chk("lit_wait_req", {31'b0, imem_req}, 1);
      step(0, 0, 0, 0, 0, 32'hBAD0_BAD0);
    end
    chk("lit_wait_addr", imem_addr, 32'h10);
    step(0, 1, 0, 0, 1, 32'h0080_2083);
    chk("lit_pc10", pc_out, 32'h10);

    // stall hold
    for (int i = 0; i < 5; i++) begin
      chk("lit_stall_instr", instr, 32'h0080_2083);
      chk("lit_stall_opc", {25'b0, opcode}, 32'h03);
      chk("lit_stall_req", {31'b0, imem_req}, 0);
      step(0, 1, 0, 0, 1, 32'h1111_1111);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("lit_addr14", imem_addr, 32'h14);

    // redirect from FETCH with ready, then wrong-path flush with two redirects
    step(0, 0, 1, 32'h20, 1, 32'hDEAD_0001);
    chk("lit_redir20", imem_addr, 32'h20);
    step(0, 0, 1, 32'h103, 0, 0);
    chk("lit_flush_hold", imem_addr, 32'h20);
    step(0, 0, 1, 32'h200, 0, 0);
    chk("lit_flush_hold2", imem_addr, 32'h20);
    step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("lit_addr200", imem_addr, 32'h200);
    chk("lit_no_valid20", {31'b0, instr_valid}, 0);
    step(0, 0, 0, 0, 1, 32'h13);
    chk("lit_pc200", pc_out, 32'h200);

    // redirect arriving in the same cycle as the wrong-path ready
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h300, 0, 0);
    step(0, 0, 1, 32'h401, 1, 32'hDEAD_0002);
    chk("lit_addr400", imem_addr, 32'h400);
    step(0, 0, 0, 0, 1, 32'h6F);
    chk("lit_pc400", pc_out, 32'h400);

    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    chk("lit_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1, 32'h33);
    step(0, 0, 0, 0, 0, 0);
    chk("lit_wrap", imem_addr, 32'h0);
    step(0, 0, 0, 0, 1, 32'h33);
    step(0, 0, 0, 0, 0, 0);

    // reset in FETCH with ready in the same cycle
    chk("lit_pre_rst_addr", imem_addr, 32'h4);
    step(1, 0, 0, 0, 1, 32'h1234_5678);
    chk("lit_rst2_req", {31'b0, imem_req}, 0);
    chk("lit_rst2_valid", {31'b0, instr_valid}, 0);
    chk("lit_rst2_instr", instr, 0);
    chk("lit_rst2_addr", imem_addr, RST_PC);
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    chk("lit_restart_addr", imem_addr, RST_PC);
    step(0, 0, 0, 0, 1, 32'h33);
    chk("lit_restart_instr", instr, 32'h33);
    step(0, 0, 0, 0, 0, 0);

    // reset mid-flush, then a short streaming run
    step(0, 0, 1, 32'h80, 0, 0);
    step(1, 0, 0, 0, 1, 32'h5555_5555);
    for (int i = 0; i < 12; i++) step(0, i[1], 0, 0, i[0], 32'h100 + i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
